// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit for the execute stage.
//
// Owns the architectural HI/LO registers. A Start in IDLE computes the
// result from A/B on that edge, parks it in pending registers and holds
// Busy for MULT_CYCLES or DIV_CYCLES cycles. On the final edge HI/LO take
// the pending value and Busy drops in the same cycle. A division by zero
// still runs the full Busy window but leaves HI/LO untouched.
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset_n  in   1   synchronous active-low reset
//   Start    in   1   launch mult/multu/div/divu (accepted only in IDLE)
//   MDSign   in   1   1 = signed operation
//   MD       in   1   Start: 0 mul / 1 div; HLWrite: 0 HI / 1 LO
//   HLWrite  in   1   mthi/mtlo request (IDLE only, Start has priority)
//   A        in  32   rs operand
//   B        in  32   rt operand
//   Busy     out  1   operation in flight (flop output)
//   HI       out 32   HI register (flop output)
//   LO       out 32   LO register (flop output)

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic        MDSign,
  input  logic        MD,
  input  logic        HLWrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_busy, w_busy_nxt;
  logic        w_accept;
  logic        w_hl_wr;
  logic        w_commit;

  logic [31:0] r_phi, r_plo;
  logic        r_pdivz;
  logic [63:0] w_mul_res;
  logic [63:0] w_div_res;

  // 64-bit product; signed mode sign-extends both operands, so the low
  // 64 bits of the extended product are the exact two's-complement result.
  function automatic logic [63:0] f_mul(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        sgn);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] p;
    ea = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'd0, a});
    eb = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
    p  = ea * eb;
    return p;
  endfunction

  // Returns {remainder, quotient}. Signed division is done on magnitudes
  // so 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of
  // hitting a simulator-defined overflow. Divide-by-zero yields 0 here;
  // the caller suppresses the writeback anyway.
  function automatic logic [63:0] f_div(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? (~a + 32'd1) : a;
    mb    = neg_b ? (~b + 32'd1) : b;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (neg_a ^ neg_b) q = ~q + 32'd1;
    if (neg_a)         r = ~r + 32'd1;
    return {r, q};
  endfunction

  assign w_mul_res = f_mul(A, B, MDSign);
  assign w_div_res = f_div(A, B, MDSign);

  // Control FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Control FSM: next state, counter and strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_accept    = 1'b0;
    w_hl_wr     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_accept    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = MD ? S_DIV : S_MUL;
          w_cnt_nxt   = MD ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
        end else if (HLWrite) begin
          w_hl_wr = 1'b1;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Pending result capture. No reset: a reset returns the FSM to IDLE,
  // so whatever is parked here is never committed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pdivz <= MD && (B == 32'd0);
      if (MD) begin
        r_phi <= w_div_res[63:32];
        r_plo <= w_div_res[31:0];
      end else begin
        r_phi <= w_mul_res[63:32];
        r_plo <= w_mul_res[31:0];
      end
    end
  end

  // Architectural HI/LO
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (w_commit) begin
      if (!r_pdivz) begin
        HI <= r_phi;
        LO <= r_plo;
      end
    end else if (w_hl_wr) begin
      if (MD) LO <= A;
      else    HI <= A;
    end
  end

  assign Busy = r_busy;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  logic        MDSign;
  logic        MD;
  logic        HLWrite;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start   (Start),
    .MDSign  (MDSign),
    .MD      (MD),
    .HLWrite (HLWrite),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  // Reference model straight from the arithmetic rules, using 64-bit math.
  task automatic model_op(input bit md, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    if (!md) begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
        sp = sa * sb;
        exp_hi = sp[63:32];
        exp_lo = sp[31:0];
      end else begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        up = ua * ub;
        exp_hi = up[63:32];
        exp_lo = up[31:0];
      end
    end else if (b != 32'd0) begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
        sq = sa / sb;
        sr = sa % sb;
        exp_lo = sq[31:0];
        exp_hi = sr[31:0];
      end else begin
        exp_lo = a / b;
        exp_hi = a % b;
      end
    end
  endtask

  // Called just after a negedge; presents Start for one rising edge.
  task automatic do_start(input bit md, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b);
    Start  = 1'b1;
    MD     = md;
    MDSign = sgn;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Counts negedges with Busy high; returns at the first negedge with Busy low.
  task automatic run_busy(output int n);
    n = 0;
    @(negedge clk);
    while (Busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    Start = 1'b0; HLWrite = 1'b0; MD = 1'b0; MDSign = 1'b0;
    A = 32'hDEADBEEF; B = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({Busy, HI, LO} !== {1'b0, 64'd0}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got Busy=%b HI=%h LO=%h want 0/0/0", i, Busy, HI, LO);
      end
    end
  endtask

  task automatic test_multu;
    int n;
    do_start(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_busy(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL multu_busy got %0d want 5", n);
    end
    checks++;
    if (HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_result got HI=%h LO=%h want FFFFFFFE 00000001", HI, LO);
    end
    exp_hi = 32'hFFFFFFFE; exp_lo = 32'h00000001;
  endtask

  task automatic test_mult;
    int n;
    do_start(1'b0, 1'b1, 32'hFFFFFFFE, 32'd3);
    run_busy(n);
    checks++;
    if (n !== 5 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_neg got busy=%0d HI=%h LO=%h want 5 FFFFFFFF FFFFFFFA", n, HI, LO);
    end
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFA;
  endtask

  task automatic test_div;
    int n;
    do_start(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
    run_busy(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL div_busy got %0d want 10", n);
    end
    checks++;
    if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_result got HI=%h LO=%h want FFFFFFFF FFFFFFFD", HI, LO);
    end
    // divu 7/0 right behind it: full busy window, HI/LO unchanged
    do_start(1'b1, 1'b0, 32'd7, 32'd0);
    run_busy(n);
    checks++;
    if (n !== 10 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL divu_by_zero got busy=%0d HI=%h LO=%h want 10 FFFFFFFF FFFFFFFD", n, HI, LO);
    end
    // most-negative / -1 does not trap
    do_start(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    run_busy(n);
    checks++;
    if (n !== 10 || HI !== 32'd0 || LO !== 32'h80000000) begin
      errors++;
      $display("FAIL div_overflow got busy=%0d HI=%h LO=%h want 10 00000000 80000000", n, HI, LO);
    end
    exp_hi = 32'd0; exp_lo = 32'h80000000;
  endtask

  task automatic test_hlwrite;
    HLWrite = 1'b1; MD = 1'b0; A = 32'h12345678;
    @(posedge clk);
    #1;
    MD = 1'b1; A = 32'h9ABCDEF0;
    @(negedge clk);
    checks++;
    if (HI !== 32'h12345678 || LO !== exp_lo || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi got HI=%h LO=%h Busy=%b want 12345678 %h 0", HI, LO, Busy, exp_lo);
    end
    @(posedge clk);
    #1;
    HLWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (HI !== 32'h12345678 || LO !== 32'h9ABCDEF0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo got HI=%h LO=%h Busy=%b want 12345678 9ABCDEF0 0", HI, LO, Busy);
    end
    exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_ignored;
    int n;
    do_start(1'b0, 1'b0, 32'd7, 32'd6);
    n = 0;
    @(negedge clk);
    while (Busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin
        Start = 1'b1; HLWrite = 1'b1; MD = 1'b1; MDSign = 1'b0;
        A = 32'd100; B = 32'd0;
        @(posedge clk);
        #1;
        Start = 1'b0; HLWrite = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 5 || HI !== 32'd0 || LO !== 32'd42) begin
      errors++;
      $display("FAIL ignored_while_busy got busy=%0d HI=%h LO=%h want 5 00000000 0000002a", n, HI, LO);
    end
    exp_hi = 32'd0; exp_lo = 32'd42;
  endtask

  task automatic test_reset_mid;
    int n;
    bit ok;
    do_start(1'b1, 1'b1, 32'd100, 32'd7);
    n = 0;
    @(negedge clk);
    while (Busy === 1'b1 && n < 40) begin
      n++;
      if (n == 4) begin
        reset_n = 1'b0; Start = 1'b1; HLWrite = 1'b1; MD = 1'b0; A = 32'd5;
        @(posedge clk);
        #1;
        reset_n = 1'b1; Start = 1'b0; HLWrite = 1'b0;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 4 || Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got n=%0d Busy=%b HI=%h LO=%h want 4 0 0 0", n, Busy, HI, LO);
    end
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_no_late_writeback got Busy=%b HI=%h LO=%h want 0 0 0", Busy, HI, LO);
    end
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  task automatic test_back_to_back;
    int n;
    int kind;
    bit md, sgn;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h000000FF;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      md  = $urandom_range(0, 1);
      sgn = $urandom_range(0, 1);
      if (kind == 5) begin
        HLWrite = 1'b1; MD = md; A = a;
        @(posedge clk);
        #1;
        HLWrite = 1'b0;
        if (md) exp_lo = a; else exp_hi = a;
        @(negedge clk);
        checks++;
        if (HI !== exp_hi || LO !== exp_lo || Busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_hlwrite i=%0d got HI=%h LO=%h Busy=%b want %h %h 0", i, HI, LO, Busy, exp_hi, exp_lo);
        end
      end else begin
        do_start(md, sgn, a, b);
        model_op(md, sgn, a, b);
        run_busy(n);
        checks++;
        if (n !== (md ? 10 : 5) || HI !== exp_hi || LO !== exp_lo) begin
          errors++;
          $display("FAIL rand_op i=%0d md=%b s=%b a=%h b=%h got n=%0d HI=%h LO=%h want n=%0d %h %h",
                   i, md, sgn, a, b, n, HI, LO, (md ? 10 : 5), exp_hi, exp_lo);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_hlwrite;
    test_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the execute stage. It consumes the MD control bundle produced by the instruction decoder (Start, MDSign, MD, HLWrite) together with the forwarded rs/rt operands. It runs multi-cycle mult/multu/div/divu operations and owns the architectural HI/LO registers. It also reports Busy, so that the hazard unit can stall any MD-using instruction (MDUse) while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (2..15)
- DIV_CYCLES, 10, Busy duration for div/divu (2..15)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset_n  input  1  synchronous, active-low reset
- Start  input  1  launch a mult/multu/div/divu this cycle
- MDSign  input  1  1 = signed operation (mult/div)
- MD  input  1  with Start: 0 = multiply, 1 = divide; with HLWrite: 0 = write HI, 1 = write LO
- HLWrite  input  1  mthi/mtlo write request
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- Busy  output  1  operation in flight (registered)
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- State machine: IDLE, MUL, DIV. A 4-bit down-counter `cnt` sits beside it.
- Reset (reset_n=0 at an edge):
  - state goes to IDLE, cnt to 0, Busy to 0, HI to 0, LO to 0.
  - Any pending result is discarded.
- IDLE, Start=1:
  - The result is computed from A/B sampled at this edge and held in pending registers pHI/pLO.
  - MD=0: state goes to MUL and cnt loads MULT_CYCLES-1.
  - MD=1: state goes to DIV and cnt loads DIV_CYCLES-1.
  - Busy goes to 1.
- MUL/DIV with cnt≠0: cnt decrements by 1.
- MUL/DIV with cnt=0:
  - HI←pHI, LO←pLO.
  - Exception: for division by zero, HI and LO are left unchanged.
  - state goes to IDLE and Busy goes to 0.
- Arithmetic:
  - multu: {HI,LO} = zero-extended A × B (64 bits).
  - mult: {HI,LO} = signed 64-bit product.
  - divu: LO = A/B and HI = A%B, both unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder, which takes the sign of A.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 and does not trap.
- HLWrite in IDLE (Start=0): MD=0 writes HI←A; MD=1 writes LO←A. The write is visible the next cycle.
- Simultaneous events:
  - Start and HLWrite together: Start wins and HLWrite is ignored.
  - Start or HLWrite while Busy=1: ignored. Upstream must stall on MDUse && Busy, so this case is a protocol violation and leaves no side effects.
  - Start with MDSign=1 is signed; Start with MDSign=0 is unsigned.
- While Busy=1, HI/LO keep their old values. mfhi/mflo stall upstream and never read stale data.

## Timing
- Start sampled at edge E0:
  - Busy=1 from E0 through the edge E0+N-1, i.e. for exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
  - At edge E0+N, HI/LO update and Busy returns to 0 together, in the same cycle.
- Back-to-back: a Start presented in the first cycle with Busy=0 is accepted. There is no dead cycle.
- HLWrite: 1-cycle latency and never sets Busy.
- Busy, HI and LO are driven directly from flops, with no combinational path from inputs.
- Reset mid-operation takes effect at the next edge. It overrides Start and HLWrite in the same cycle.

## Test plan
- Reset, then idle: HI=0, LO=0, Busy=0 at every cycle.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF:
  - Busy is high for exactly 5 cycles.
  - Then HI=0xFFFFFFFE, LO=0x00000001.
- mult A=0xFFFFFFFE (-2), B=3: after 5 cycles, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2:
  - Busy is high for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Follow with divu 7/0: Busy high for 10 cycles, HI/LO unchanged afterwards.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles:
  - HI and LO update one cycle after each write.
  - A Start issued while Busy, and an HLWrite issued while Busy, both leave state unchanged.
- Start a div, then pull reset_n low at the 4th Busy cycle:
  - The next cycle shows Busy=0, HI=0, LO=0.
  - No late result writeback occurs.
